iq_avg_snap_ctrl: RTL
=====================

Name: iq_avg_snap_ctrl

Overview:
- Per-channel I/Q frame averager and snapshot controller. Consumes the channelised I/Q stream, sums 2^avg_log2 frames per channel in an internal accumulator RAM, and writes the averaged I/Q into the snapshot BRAM.
- Produces the 32-bit status word that feeds the iq_avg2 status software register (user_data_in, user_clk domain).
- The software register wrapper handles the OPB-side clock crossing; this block lives entirely in user_clk.

Parameters:
- N_CHAN_LOG2, 8, log2 of channels per frame; also the width of the accumulator and snapshot address.
- DATA_W, 16, signed width of each of I and Q.
- ACC_W, 32, accumulator width per component; must be >= DATA_W+MAX_AVG_LOG2.
- MAX_AVG_LOG2, 12, largest permitted avg_log2.

Ports:
- user_clk  in  1  sole clock.
- user_rst  in  1  synchronous, active-high reset.
- ctrl_in  in  32  control word: bit0 = start (acts on its rising edge); bits[11:8] = avg_log2.
- in_valid  in  1  sample qualifier.
- in_chan  in  N_CHAN_LOG2  channel index; increments by 1 modulo 2^N_CHAN_LOG2 on each valid sample.
- in_i  in  DATA_W  signed I.
- in_q  in  DATA_W  signed Q.
- snap_we  out  1  snapshot BRAM write enable.
- snap_addr  out  N_CHAN_LOG2  snapshot address, equal to the channel.
- snap_data  out  2*DATA_W  {I_avg, Q_avg}.
- status_out  out  32  status word to the status register.

Behaviour:
- Interface: one clock, user_clk; reset is synchronous and active-high (user_rst).
- Reset values: snap_we=0, snap_addr=0, snap_data=0, status_out=0, state=IDLE, all counters 0. Accumulator RAM contents are not reset; the first frame overwrites them.
- start_edge = ctrl_in[0] & ~ctrl_in_d[0], using a registered copy of ctrl_in[0].
- avg_log2 is latched on start_edge and clamped to MAX_AVG_LOG2 if larger.
- FSM states: IDLE, ARM, ACCUM.
  - IDLE: on start_edge -> ARM. Latch avg_log2, clear done and overrun, clear frame_cnt. A start_edge in any other state is ignored.
  - ARM: wait for in_valid with in_chan==0 -> ACCUM. That sample is processed as frame 0.
  - ACCUM: a frame completes on each in_valid with in_chan==all-ones; frame_cnt then increments. After the sample at in_chan==all-ones of frame 2^avg_log2-1 -> IDLE, and done is set.
- Accumulator pipeline (2 stages, sub-module RAM with 1-cycle read latency):
  - S0: read addr=in_chan; register sample, chan, first=(frame_cnt==0), last=(frame_cnt==2^avg_log2-1).
  - S1: sum = (first ? 0 : ram_rd) + sign_extend(sample), computed for each component at ACC_W.
    - If !last: write sum back to the RAM.
    - If last: snap_we=1, snap_addr=chan, snap_data = {sum_I>>>avg_log2, sum_Q>>>avg_log2} truncated to DATA_W. Shift is arithmetic, floor rounding, no saturation needed.
  - snap_we asserts exactly 2 cycles after the qualifying in_valid; it is a 1-cycle pulse per channel.
  - No read/write hazard, because a channel repeats no sooner than 2^N_CHAN_LOG2 (>=4) samples.
- avg_log2=0: first and last are both set, so snap_data equals the input sample.
- Samples with in_valid=0 are ignored. Gaps between valid samples are legal.
- Overrun (sticky until the next accepted start): set if, in ACCUM, in_valid arrives with in_chan != expected_chan. expected_chan is the previous valid chan+1. The sample is still processed using its in_chan.
- The pipeline drains after ACCUM->IDLE. The S1 write for the final sample completes.
- status_out is registered and updated every cycle:
  - [0] done
  - [1] busy (state != IDLE or pipeline non-empty)
  - [2] armed (state==ARM)
  - [3] overrun
  - [7:4] latched avg_log2
  - [20:8] frame_cnt (13 bits; max 4096)
  - [31:21] = 0
- user_rst mid-operation: returns to IDLE immediately, any in-flight snap_we is suppressed, status_out=0.

Decomposition:
- Shared package iq_avg_pkg holds:
  - state enum {IDLE, ARM, ACCUM}
  - status bit index constants (DONE=0, BUSY=1, ARMED=2, OVR=3, AVG_LSB=4, FCNT_LSB=8)
  - ctrl bit constants (START=0, AVG_LSB=8)
- Sub-module iq_acc_ram: simple dual-port, 2^N_CHAN_LOG2 x 2*ACC_W, sync write, registered read (1 cycle).

Test Plan:
- Reset/idle: assert user_rst 3 cycles, with ctrl_in=1 held -> status_out=0, snap_we never asserted, no start taken until the next 0->1 edge.
- avg_log2=0, N_CHAN_LOG2=2: start; stream chans 0..3 with I=chan*10, Q=-chan -> 4 snap_we pulses, each 2 cycles after its input, snap_data {0,0},{10,-1},{20,-2},{30,-3}; done=1, busy=0, frame_cnt=1.
- avg_log2=2: feed 4 frames with I = 1, 2, 3, 5 and Q = -1, -2, -3, -5 on every chan -> I_avg=2 (11>>>2) and Q_avg=-3 (floor of -11/4), frame_cnt=4, status_out[7:4]=2.
- Arm alignment: start, then the stream begins at chan 2 -> stays ARM (bit2=1) until chan 0; the partial frame is not accumulated.
- Overrun: during ACCUM send chan 0,1,3 -> status bit3=1 persists after done, and clears on the next start_edge.
- Restart and reset mid-run: start_edge during ACCUM is ignored (avg_log2 unchanged). user_rst asserted during frame 1 -> status_out=0, no further snap_we; a new start then completes normally with correct averages.

Source files
------------

// File: rtl/iq_avg_pkg.sv
// Shared types and constants for the I/Q frame averager / snapshot controller.
package iq_avg_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2
    } state_e;

    // Status word bit positions
    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_ARMED    = 2;
    localparam int ST_OVR      = 3;
    localparam int ST_AVG_LSB  = 4;
    localparam int ST_FCNT_LSB = 8;

    // Control word bit positions
    localparam int CTRL_START   = 0;
    localparam int CTRL_AVG_LSB = 8;

    // Field widths
    localparam int AVG_W  = 4;
    localparam int FCNT_W = 13;

    // Limit the requested averaging exponent to the supported maximum
    function automatic logic [AVG_W-1:0] clamp_avg(input logic [AVG_W-1:0] raw,
                                                   input logic [AVG_W-1:0] lim);
        if (raw > lim) begin
            return lim;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/iq_acc_ram.sv
// Simple dual-port accumulator RAM: synchronous write, registered read.
// Contents are deliberately not reset; the first frame overwrites them.
module iq_acc_ram #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, one cycle latency
    always_ff @(posedge clk_i) begin
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/iq_avg_snap_ctrl.sv
// Per-channel I/Q frame averager and snapshot controller. Sums 2^avg_log2
// frames per channel and writes the arithmetic-shift average to the
// snapshot BRAM; also produces the 32-bit status word.
module iq_avg_snap_ctrl
    import iq_avg_pkg::*;
#(
    parameter int N_CHAN_LOG2  = 8,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 32,
    parameter int MAX_AVG_LOG2 = 12
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            ctrl_in,
    input  logic                   in_valid,
    input  logic [N_CHAN_LOG2-1:0] in_chan,
    input  logic [DATA_W-1:0]      in_i,
    input  logic [DATA_W-1:0]      in_q,
    output logic                   snap_we,
    output logic [N_CHAN_LOG2-1:0] snap_addr,
    output logic [2*DATA_W-1:0]    snap_data,
    output logic [31:0]            status_out
);

    localparam logic [N_CHAN_LOG2-1:0] CHAN_LAST = {N_CHAN_LOG2{1'b1}};
    localparam logic [N_CHAN_LOG2-1:0] CHAN_ONE  = N_CHAN_LOG2'(1);
    localparam logic [AVG_W-1:0]       AVG_MAX   = AVG_W'(MAX_AVG_LOG2);

    // Control state
    state_e                  state_q;
    logic                    ctrl_start_q;
    logic [AVG_W-1:0]        avg_log2_q;
    logic [FCNT_W-1:0]       frame_cnt_q;
    logic                    done_q;
    logic                    ovr_q;
    logic [N_CHAN_LOG2-1:0]  exp_chan_q;

    // Pipeline stage S0
    logic                    s0_vld_q;
    logic [N_CHAN_LOG2-1:0]  s0_chan_q;
    logic [DATA_W-1:0]       s0_i_q;
    logic [DATA_W-1:0]       s0_q_q;
    logic                    s0_first_q;
    logic                    s0_last_q;
    logic [AVG_W-1:0]        s0_shift_q;

    // Combinational helpers
    logic                    start_edge_s;
    logic [FCNT_W-1:0]       frame_last_s;
    logic                    accept_s;
    logic [2*ACC_W-1:0]      ram_rd_s;
    logic                    ram_we_s;
    logic signed [ACC_W-1:0] ext_i_s, ext_q_s;
    logic signed [ACC_W-1:0] base_i_s, base_q_s;
    logic signed [ACC_W-1:0] sum_i_s, sum_q_s;
    logic signed [ACC_W-1:0] shr_i_s, shr_q_s;
    logic [31:0]             status_s;
    logic                    ctrl_unused_s;

    assign ctrl_unused_s = ^{ctrl_in[31:12], ctrl_in[7:1]};
    assign start_edge_s  = ctrl_in[CTRL_START] & ~ctrl_start_q;
    assign frame_last_s  = (FCNT_W'(1) << avg_log2_q) - FCNT_W'(1);

    // Decide whether the current input sample enters the accumulator pipeline
    always_comb begin
        accept_s = 1'b0;
        if (in_valid) begin
            case (state_q)
                ARM:     accept_s = (in_chan == '0);
                ACCUM:   accept_s = 1'b1;
                default: accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM: start detection, arming, frame counting, done/overrun flags
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q      <= IDLE;
            // Track the live start bit through reset so a level held high
            // across reset is not mistaken for a fresh rising edge.
            ctrl_start_q <= ctrl_in[CTRL_START];
            avg_log2_q   <= '0;
            frame_cnt_q  <= '0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            exp_chan_q   <= '0;
        end else begin
            ctrl_start_q <= ctrl_in[CTRL_START];
            if (accept_s) begin
                exp_chan_q <= in_chan + CHAN_ONE;
            end
            case (state_q)
                IDLE: begin
                    if (start_edge_s) begin
                        state_q     <= ARM;
                        avg_log2_q  <= clamp_avg(ctrl_in[CTRL_AVG_LSB +: AVG_W], AVG_MAX);
                        done_q      <= 1'b0;
                        ovr_q       <= 1'b0;
                        frame_cnt_q <= '0;
                    end
                end
                ARM: begin
                    if (accept_s) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (in_chan != exp_chan_q) begin
                            ovr_q <= 1'b1;
                        end
                        if (in_chan == CHAN_LAST) begin
                            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                            if (frame_cnt_q == frame_last_s) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    iq_acc_ram #(
        .AW (N_CHAN_LOG2),
        .DW (2*ACC_W)
    ) u_ram (
        .clk_i   (user_clk),
        .we_i    (ram_we_s),
        .waddr_i (s0_chan_q),
        .wdata_i ({sum_i_s, sum_q_s}),
        .raddr_i (in_chan),
        .rdata_o (ram_rd_s)
    );

    // S1 arithmetic: add the sample to the running sum and form the average
    always_comb begin
        ext_i_s = {{(ACC_W-DATA_W){s0_i_q[DATA_W-1]}}, s0_i_q};
        ext_q_s = {{(ACC_W-DATA_W){s0_q_q[DATA_W-1]}}, s0_q_q};
        if (s0_first_q) begin
            base_i_s = '0;
            base_q_s = '0;
        end else begin
            base_i_s = $signed(ram_rd_s[2*ACC_W-1:ACC_W]);
            base_q_s = $signed(ram_rd_s[ACC_W-1:0]);
        end
        sum_i_s  = base_i_s + ext_i_s;
        sum_q_s  = base_q_s + ext_q_s;
        shr_i_s  = sum_i_s >>> s0_shift_q;
        shr_q_s  = sum_q_s >>> s0_shift_q;
        ram_we_s = s0_vld_q & ~s0_last_q;
    end

    // Accumulator pipeline registers and snapshot write outputs
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            s0_vld_q   <= 1'b0;
            s0_chan_q  <= '0;
            s0_i_q     <= '0;
            s0_q_q     <= '0;
            s0_first_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_shift_q <= '0;
            snap_we    <= 1'b0;
            snap_addr  <= '0;
            snap_data  <= '0;
        end else begin
            s0_vld_q <= accept_s;
            if (accept_s) begin
                s0_chan_q  <= in_chan;
                s0_i_q     <= in_i;
                s0_q_q     <= in_q;
                s0_first_q <= (frame_cnt_q == '0);
                s0_last_q  <= (frame_cnt_q == frame_last_s);
                // Carry the shift with the sample so a quick restart cannot
                // change it before the final sum is scaled.
                s0_shift_q <= avg_log2_q;
            end
            snap_we <= s0_vld_q & s0_last_q;
            if (s0_vld_q & s0_last_q) begin
                snap_addr <= s0_chan_q;
                snap_data <= {shr_i_s[DATA_W-1:0], shr_q_s[DATA_W-1:0]};
            end
        end
    end

    // Assemble the status word from current state
    always_comb begin
        status_s                           = 32'd0;
        status_s[ST_DONE]                  = done_q;
        status_s[ST_BUSY]                  = (state_q != IDLE) | s0_vld_q;
        status_s[ST_ARMED]                 = (state_q == ARM);
        status_s[ST_OVR]                   = ovr_q;
        status_s[ST_AVG_LSB +: AVG_W]      = avg_log2_q;
        status_s[ST_FCNT_LSB +: FCNT_W]    = frame_cnt_q;
    end

    // Registered status output
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            status_out <= 32'd0;
        end else begin
            status_out <= status_s;
        end
    end

endmodule
